// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory port arbiter: requester count,
// requester indices, default widths and a modulo-NUM_REQ increment helper.
package mem_arb_pkg;

    localparam int NUM_REQ    = 3;
    localparam int IDX_W      = 2;
    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    localparam int REQ_UART = 0;
    localparam int REQ_CPU  = 1;
    localparam int REQ_DDU  = 2;

    // Next requester index, wrapping NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= NUM_REQ - 1)
            return '0;
        else
            return i + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping
// modulo NUM_REQ; the first set bit wins. Reusable for any shared resource.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    // Priority scan from ptr, wrapping around once.
    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && req[idx]) begin
                found    = 1'b1;
                winner   = idx;
                gnt[idx] = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the CPU-side port of the unified memory.
// Requesters: UART loader (0), CPU (1), debug display unit (2).
// Optional grant lock for uninterrupted bursts: define MEM_ARB_LOCK_EN.
//
// Handshake: a requester raises req with we/addr/wdata stable; the access is
// accepted in the cycle gnt is high (combinational). On the next cycle the
// requester either drops req or presents its next access. A granted read
// returns rvalid (one-hot, one cycle) with rdata on the following cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          lock,
`endif
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [31:0]                 conflict_cnt
);

    logic [IDX_W-1:0]   ptr;
    logic [31:0]        conflict_q;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               hold;
    logic [IDX_W-1:0]   hold_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt    (pick_gnt),
        .winner (pick_idx),
        .found  (pick_found)
    );

`ifdef MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0] lock_owner;

    // Lock holds while the owner keeps both req and lock asserted.
    always_comb begin
        hold     = 1'b0;
        hold_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lock_owner[i] && req[i] && lock[i]) begin
                hold     = 1'b1;
                hold_idx = i[IDX_W-1:0];
            end
        end
    end

    // Capture the owner whenever a locking requester is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_owner <= '0;
        end else begin
            lock_owner <= '0;
            if (win_valid && lock[win_idx])
                lock_owner[win_idx] <= 1'b1;
        end
    end
`else
    assign hold     = 1'b0;
    assign hold_idx = '0;
`endif

    assign win_idx   = hold ? hold_idx : pick_idx;
    assign win_valid = (hold | pick_found) & ~rst;

    // Grant and memory-port mux; everything forced idle while in reset.
    always_comb begin
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win_valid) begin
            if (hold)
                gnt[hold_idx] = 1'b1;
            else
                gnt = pick_gnt;
            mem_en    = 1'b1;
            mem_we    = we[win_idx];
            mem_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
            mem_wdata = wdata[int'(win_idx)*DATA_W +: DATA_W];
        end
    end

    // Pointer rotation, read-return tagging and contention counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            rvalid     <= '0;
            conflict_q <= '0;
        end else begin
            rvalid <= '0;
            if (win_valid) begin
                if (!we[win_idx])
                    rvalid[win_idx] <= 1'b1;
                if (!hold)
                    ptr <= next_idx(win_idx);
            end
            if ($countones(req) >= 2)
                conflict_q <= conflict_q + 32'd1;
        end
    end

    assign rdata        = mem_rdata;
    assign conflict_cnt = conflict_q;

endmodule
